jtframe_prog_feeder: RTL

JTFRAME_PROG_FEEDER -- requirements
Module: jtframe_prog_feeder

---
 rtl/jtframe_prog_feeder.sv | 96 +++++++++
 1 files changed

// File: rtl/jtframe_prog_feeder.sv
// jtframe_prog_feeder: turns ioctl ROM download bytes into buffered SDRAM programming writes
// Ports:
//   rst, clk_rom                 async active-high reset, rising-edge clock
//   ioctl_addr/data/rom_wr       incoming download byte and its one-cycle strobe
//   downloading                  high for the whole ROM transfer
//   prog_ack                     SDRAM controller accepted the current write
//   prog_addr/data/mask/bank/we  write request towards the SDRAM controller
//   dwnld_busy                   download path still active (includes the tail)
//   overflow                     sticky: a byte was dropped because the FIFO was full
module jtframe_prog_feeder #(
  parameter logic [24:0] BA1_START = 25'h080000,
  parameter logic [24:0] BA2_START = 25'h100000,
  parameter logic [24:0] BA3_START = 25'h180000,
  parameter int          TAIL      = 16
)(
  input  logic        rst,
  input  logic        clk_rom,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_rom_wr,
  input  logic        downloading,
  input  logic        prog_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  output logic        dwnld_busy,
  output logic        overflow
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2;
  localparam int TW = $clog2(TAIL + 2);
  logic [1:0]    in_bank, st;
  logic [22:0]   in_off;
  logic [33:0]   in_ent, s1_ent;
  logic [33:0]   mem [4];
  logic          s1_valid, dl_d, pop, push_ok, drop, active;
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    cnt;
  logic [TW-1:0] tail;
  // Entry layout: {bank, word address, data, active-low byte mask}
  always_comb begin
    in_bank = ioctl_addr >= BA3_START ? 2'd3 : ioctl_addr >= BA2_START ? 2'd2 :
              ioctl_addr >= BA1_START ? 2'd1 : 2'd0;
    in_off  = 23'(ioctl_addr - (in_bank == 2'd3 ? BA3_START : in_bank == 2'd2 ? BA2_START :
                                in_bank == 2'd1 ? BA1_START : 25'd0));
    in_ent  = {in_bank, in_off[22:1], ioctl_data, in_off[0] ? 2'b01 : 2'b10};
    pop     = st == REQ && prog_ack;
    // A full FIFO still accepts the push when the head leaves in the same cycle
    push_ok = s1_valid && (cnt != 3'd4 || pop);
    drop    = s1_valid && cnt == 3'd4 && !pop;
    active  = downloading || s1_valid || cnt != 3'd0 || st != IDLE;
    dwnld_busy = !rst && (active || tail != '0);
  end
  always_ff @(posedge clk_rom)
    if (push_ok) mem[wr_ptr] <= s1_ent;
  always_ff @(posedge clk_rom or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ent   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      dl_d     <= 1'b0;
      tail     <= '0;
    end else begin
      s1_valid <= ioctl_rom_wr;
      if (ioctl_rom_wr) s1_ent <= in_ent;
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      cnt      <= cnt + {2'd0, push_ok} - {2'd0, pop};
      dl_d     <= downloading;
      overflow <= (overflow && !(downloading && !dl_d)) || drop;
      // Held at TAIL while anything is active, so it counts down from the first idle cycle
      tail     <= active ? TW'(TAIL) : tail != '0 ? tail - TW'(1) : tail;
    end
  // IDLE and GAP behave alike except GAP still counts as busy; both keep prog_we low for the cycle
  always_ff @(posedge clk_rom or posedge rst)
    if (rst) begin
      st      <= IDLE;
      prog_we <= 1'b0;
      {prog_bank, prog_addr, prog_data, prog_mask} <= {2'd0, 22'd0, 8'd0, 2'b11};
    end else if (st == REQ) begin
      if (prog_ack) begin
        st      <= GAP;
        prog_we <= 1'b0;
      end
    end else if (cnt != 3'd0) begin
      st      <= REQ;
      prog_we <= 1'b1;
      {prog_bank, prog_addr, prog_data, prog_mask} <= mem[rd_ptr];
    end else begin
      st <= IDLE;
    end
endmodule
